// File: rtl/game_ctrl.sv
// Game controller for the runner game: start/run/over sequencing, collision detection,
// BCD score keeping and scroll-speed stepping. All outputs are registered.
module game_ctrl #(
  parameter logic [9:0] DINO_X    = 10'd64,
  parameter logic [9:0] DINO_W    = 10'd20,
  parameter logic [9:0] OBST_W    = 10'd16,
  parameter logic [5:0] CLEAR_H   = 6'd12,
  parameter logic [3:0] SCORE_DIV = 4'd6
) (
  input  logic        CLK,
  input  logic        clrn,
  input  logic        tick,
  input  logic        btn_start,
  input  logic [5:0]  dinosaur_height,
  input  logic [9:0]  obstacle_x,
  input  logic        obstacle_valid,
  output logic        game_status,
  output logic [3:0]  speed,
  output logic [15:0] score,
  output logic        game_over
);

  typedef enum logic [1:0] {StIdle, StRun, StOver} state_e;

  state_e      state_q;
  logic        btn_prev_q;
  logic [3:0]  div_q;
  logic [15:0] score_q;
  logic [3:0]  speed_q;
  logic        status_q;
  logic        over_q;

  logic        start_edge;
  logic [10:0] obst_right;
  logic [10:0] dino_right;
  logic        collision;
  logic        div_wrap;
  logic        score_sat;
  logic [15:0] score_inc;
  logic        carry;
  logic        hundred_roll;

  assign start_edge = btn_start & ~btn_prev_q;

  // Widened to 11 bits so edge-of-screen obstacles cannot wrap into a false overlap.
  assign obst_right = {1'b0, obstacle_x} + {1'b0, OBST_W};
  assign dino_right = {1'b0, DINO_X} + {1'b0, DINO_W};
  assign collision  = obstacle_valid
                    & (obst_right > {1'b0, DINO_X})
                    & ({1'b0, obstacle_x} < dino_right)
                    & (dinosaur_height < CLEAR_H);

  assign div_wrap  = (div_q == (SCORE_DIV - 4'd1));
  assign score_sat = (score_q == 16'h9999);

  always_comb begin
    score_inc = score_q;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  assign hundred_roll = (score_inc[7:0] == 8'h00);

  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      state_q    <= StIdle;
      btn_prev_q <= 1'b0;
      div_q      <= 4'd0;
      score_q    <= 16'h0000;
      speed_q    <= 4'd1;
      status_q   <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      btn_prev_q <= btn_start;
      over_q     <= 1'b0;
      case (state_q)
        StIdle, StOver: begin
          if (start_edge) begin
            state_q  <= StRun;
            status_q <= 1'b1;
            score_q  <= 16'h0000;
            speed_q  <= 4'd1;
            div_q    <= 4'd0;
          end
        end
        StRun: begin
          if (tick) begin
            if (collision) begin
              state_q  <= StOver;
              status_q <= 1'b0;
              over_q   <= 1'b1;
            end else if (div_wrap) begin
              div_q <= 4'd0;
              if (!score_sat) begin
                score_q <= score_inc;
                if (hundred_roll && (speed_q != 4'd15)) begin
                  speed_q <= speed_q + 4'd1;
                end
              end
            end else begin
              div_q <= div_q + 4'd1;
            end
          end
        end
        default: begin
          state_q  <= StIdle;
          status_q <= 1'b0;
        end
      endcase
    end
  end

  assign game_status = status_q;
  assign speed       = speed_q;
  assign score       = score_q;
  assign game_over   = over_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenarios plus random play, checked against an integer-score model.
module tb_game_ctrl;

  logic       CLK = 1'b0;
  logic       clrn = 1'b0;
  logic       tick = 1'b0;
  logic       btn_start = 1'b0;
  logic [5:0] dinosaur_height = 6'd0;
  logic [9:0] obstacle_x = 10'd0;
  logic       obstacle_valid = 1'b0;

  logic        gs_s, go_s, gs_f, go_f;
  logic [3:0]  sp_s, sp_f;
  logic [15:0] sc_s, sc_f;
  logic [21:0] act_s, act_f;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 CLK = ~CLK;

  game_ctrl dut (
    .CLK(CLK), .clrn(clrn), .tick(tick), .btn_start(btn_start),
    .dinosaur_height(dinosaur_height), .obstacle_x(obstacle_x),
    .obstacle_valid(obstacle_valid), .game_status(gs_s), .speed(sp_s),
    .score(sc_s), .game_over(go_s)
  );

  game_ctrl #(.SCORE_DIV(4'd1)) dut_fast (
    .CLK(CLK), .clrn(clrn), .tick(tick), .btn_start(btn_start),
    .dinosaur_height(dinosaur_height), .obstacle_x(obstacle_x),
    .obstacle_valid(obstacle_valid), .game_status(gs_f), .speed(sp_f),
    .score(sc_f), .game_over(go_f)
  );

  assign act_s = {gs_s, sp_s, sc_s, go_s};
  assign act_f = {gs_f, sp_f, sc_f, go_f};

  // Model: st 0=idle 1=run 2=over, score as a plain decimal integer.
  typedef struct {
    int st;
    int score;
    int speed;
    int divc;
    bit go;
    bit prev;
  } mdl_t;

  mdl_t m_s, m_f;

  function automatic mdl_t mreset();
    mdl_t r;
    r.st = 0; r.score = 0; r.speed = 1; r.divc = 0; r.go = 0; r.prev = 0;
    return r;
  endfunction

  function automatic mdl_t step(mdl_t m, int div, bit tk, bit btn, int h, int ox, bit ov);
    mdl_t n = m;
    bit   edge_seen = btn && !m.prev;
    n.prev = btn;
    n.go   = 0;
    if (m.st != 1) begin
      if (edge_seen) begin
        n.st = 1; n.score = 0; n.speed = 1; n.divc = 0;
      end
    end else if (tk) begin
      if (ov && (ox + 16 > 64) && (ox < 84) && (h < 12)) begin
        n.st = 2; n.go = 1;
      end else if (m.divc == div - 1) begin
        n.divc = 0;
        if (m.score < 9999) begin
          n.score = m.score + 1;
          if ((n.score % 100 == 0) && (n.speed < 15)) n.speed = n.speed + 1;
        end
      end else begin
        n.divc = m.divc + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [15:0] bcd(int s);
    logic [15:0] b;
    b[15:12] = 4'(s / 1000);
    b[11:8]  = 4'((s / 100) % 10);
    b[7:4]   = 4'((s / 10) % 10);
    b[3:0]   = 4'(s % 10);
    return b;
  endfunction

  function automatic logic [21:0] pack(mdl_t m);
    return {(m.st == 1), 4'(m.speed), bcd(m.score), m.go};
  endfunction

  always @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      m_s <= mreset();
      m_f <= mreset();
    end else begin
      m_s <= step(m_s, 6, tick, btn_start, int'(dinosaur_height), int'(obstacle_x),
                  obstacle_valid);
      m_f <= step(m_f, 1, tick, btn_start, int'(dinosaur_height), int'(obstacle_x),
                  obstacle_valid);
    end
  end

  // Drive tick for one clock, then land on the following negedge.
  task automatic cyc(input bit tk);
    tick = tk;
    @(negedge CLK);
    tick = 1'b0;
  endtask

  task automatic start_game();
    btn_start = 1'b1;
    cyc(0);
    btn_start = 1'b0;
    cyc(0);
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (act_s !== {1'b0, 4'd1, 16'h0000, 1'b0}) begin
      n_fails++; $display("FAIL reset_state: got %h want %h", act_s, {1'b0, 4'd1, 16'h0, 1'b0});
    end
    n_checks++;
    if (act_f !== pack(m_f)) begin
      n_fails++; $display("FAIL reset_state_fast: got %h want %h", act_f, pack(m_f));
    end
    clrn = 1'b1;
    cyc(0);
    n_checks++;
    if (act_s !== {1'b0, 4'd1, 16'h0000, 1'b0}) begin
      n_fails++; $display("FAIL idle_no_start: got %h want %h", act_s, {1'b0, 4'd1, 16'h0, 1'b0});
    end
  endtask

  task automatic test_score_run();
    start_game();
    n_checks++;
    if (act_s !== {1'b1, 4'd1, 16'h0000, 1'b0}) begin
      n_fails++; $display("FAIL start_to_run: got %h want %h", act_s, {1'b1, 4'd1, 16'h0, 1'b0});
    end
    for (int i = 0; i < 12; i++) cyc(1);
    n_checks++;
    if (act_s !== {1'b1, 4'd1, 16'h0002, 1'b0}) begin
      n_fails++; $display("FAIL twelve_ticks: got %h want %h", act_s, {1'b1, 4'd1, 16'h2, 1'b0});
    end
  endtask

  task automatic test_collision();
    obstacle_valid = 1'b1; obstacle_x = 10'd70; dinosaur_height = 6'd0;
    cyc(1);
    n_checks++;
    if (act_s !== {1'b0, 4'd1, 16'h0002, 1'b1}) begin
      n_fails++; $display("FAIL collide_over: got %h want %h", act_s, {1'b0, 4'd1, 16'h2, 1'b1});
    end
    obstacle_valid = 1'b0;
    cyc(1);
    n_checks++;
    if (act_s !== {1'b0, 4'd1, 16'h0002, 1'b0}) begin
      n_fails++; $display("FAIL over_pulse_end: got %h want %h", act_s, {1'b0, 4'd1, 16'h2, 1'b0});
    end
  endtask

  task automatic test_no_collision();
    start_game();
    obstacle_valid = 1'b1; obstacle_x = 10'd70; dinosaur_height = 6'd12;
    cyc(1);
    n_checks++;
    if (act_s !== {1'b1, 4'd1, 16'h0000, 1'b0}) begin
      n_fails++; $display("FAIL clear_height: got %h want %h", act_s, {1'b1, 4'd1, 16'h0, 1'b0});
    end
    obstacle_x = 10'd48; dinosaur_height = 6'd0;
    cyc(1);
    n_checks++;
    if (act_s !== {1'b1, 4'd1, 16'h0000, 1'b0}) begin
      n_fails++; $display("FAIL left_edge_48: got %h want %h", act_s, {1'b1, 4'd1, 16'h0, 1'b0});
    end
    obstacle_x = 10'd84;
    cyc(1);
    n_checks++;
    if (act_s !== {1'b1, 4'd1, 16'h0000, 1'b0}) begin
      n_fails++; $display("FAIL right_edge_84: got %h want %h", act_s, {1'b1, 4'd1, 16'h0, 1'b0});
    end
    obstacle_x = 10'd83;
    cyc(1);
    n_checks++;
    if (act_s !== {1'b0, 4'd1, 16'h0000, 1'b1}) begin
      n_fails++; $display("FAIL right_edge_83: got %h want %h", act_s, {1'b0, 4'd1, 16'h0, 1'b1});
    end
    obstacle_valid = 1'b0;
  endtask

  task automatic test_speed();
    start_game();
    for (int i = 0; i < 99 * 6; i++) cyc(1);
    n_checks++;
    if (act_s !== {1'b1, 4'd1, 16'h0099, 1'b0}) begin
      n_fails++; $display("FAIL score_0099: got %h want %h", act_s, {1'b1, 4'd1, 16'h99, 1'b0});
    end
    for (int i = 0; i < 6; i++) cyc(1);
    n_checks++;
    if (act_s !== {1'b1, 4'd2, 16'h0100, 1'b0}) begin
      n_fails++; $display("FAIL score_0100: got %h want %h", act_s, {1'b1, 4'd2, 16'h100, 1'b0});
    end
  endtask

  task automatic test_saturation();
    obstacle_valid = 1'b1; obstacle_x = 10'd70; dinosaur_height = 6'd0;
    cyc(1);
    obstacle_valid = 1'b0;
    start_game();
    for (int i = 0; i < 9999; i++) cyc(1);
    n_checks++;
    if (act_f !== {1'b1, 4'd15, 16'h9999, 1'b0}) begin
      n_fails++; $display("FAIL reach_9999: got %h want %h", act_f, {1'b1, 4'd15, 16'h9999, 1'b0});
    end
    for (int i = 0; i < 5; i++) cyc(1);
    n_checks++;
    if (act_f !== {1'b1, 4'd15, 16'h9999, 1'b0}) begin
      n_fails++; $display("FAIL hold_9999: got %h want %h", act_f, {1'b1, 4'd15, 16'h9999, 1'b0});
    end
    n_checks++;
    if (act_s !== pack(m_s)) begin
      n_fails++; $display("FAIL long_run_slow: got %h want %h", act_s, pack(m_s));
    end
  endtask

  task automatic test_restart();
    obstacle_valid = 1'b1; obstacle_x = 10'd60; dinosaur_height = 6'd3;
    cyc(1);
    obstacle_valid = 1'b0;
    btn_start = 1'b1;
    cyc(0);
    n_checks++;
    if (act_f !== {1'b1, 4'd1, 16'h0000, 1'b0}) begin
      n_fails++; $display("FAIL restart_run: got %h want %h", act_f, {1'b1, 4'd1, 16'h0, 1'b0});
    end
    for (int i = 0; i < 6; i++) cyc(1);
    n_checks++;
    if (act_s !== {1'b1, 4'd1, 16'h0001, 1'b0}) begin
      n_fails++; $display("FAIL held_no_restart: got %h want %h", act_s, {1'b1, 4'd1, 16'h1, 1'b0});
    end
    obstacle_valid = 1'b1;
    cyc(1);
    obstacle_valid = 1'b0;
    cyc(0);
    cyc(0);
    n_checks++;
    if (act_s !== {1'b0, 4'd1, 16'h0001, 1'b0}) begin
      n_fails++; $display("FAIL held_stays_over: got %h want %h", act_s, {1'b0, 4'd1, 16'h1, 1'b0});
    end
    btn_start = 1'b0;
    cyc(0);
  endtask

  task automatic test_async_reset();
    start_game();
    for (int i = 0; i < 8; i++) cyc(1);
    @(posedge CLK);
    #2 clrn = 1'b0;
    #1;
    n_checks++;
    if (act_s !== {1'b0, 4'd1, 16'h0000, 1'b0}) begin
      n_fails++; $display("FAIL async_reset: got %h want %h", act_s, {1'b0, 4'd1, 16'h0, 1'b0});
    end
    btn_start = 1'b1;
    @(negedge CLK);
    clrn = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (act_s !== {1'b1, 4'd1, 16'h0000, 1'b0}) begin
      n_fails++; $display("FAIL held_btn_release: got %h want %h", act_s, {1'b1, 4'd1, 16'h0, 1'b0});
    end
    btn_start = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) btn_start = ~btn_start;
      tick            = ($urandom_range(0, 2) == 0);
      obstacle_valid  = ($urandom_range(0, 3) == 0);
      obstacle_x      = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(30, 110));
      dinosaur_height = 6'($urandom_range(0, 20));
      @(negedge CLK);
      n_checks++;
      if (act_s !== pack(m_s)) begin
        n_fails++; $display("FAIL random_slow @%0d: got %h want %h", i, act_s, pack(m_s));
      end
      n_checks++;
      if (act_f !== pack(m_f)) begin
        n_fails++; $display("FAIL random_fast @%0d: got %h want %h", i, act_f, pack(m_f));
      end
    end
    tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_score_run();
    test_collision();
    test_no_collision();
    test_speed();
    test_saturation();
    test_restart();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter: DINO_X, 10'd64, left x-coordinate of dinosaur hitbox (pixels).
REQ-002 Parameter: DINO_W, 10'd20, dinosaur hitbox width.
REQ-003 Parameter: OBST_W, 10'd16, obstacle hitbox width.
REQ-004 Parameter: CLEAR_H, 6'd12, minimum dinosaur_height that clears an obstacle.
REQ-005 Parameter: SCORE_DIV, 4'd6, frame ticks per score point; legal range 1..15.
REQ-006 Port: CLK  input  1  system clock; all state rising-edge.
REQ-007 Port: clrn  input  1  reset, asynchronous, active-low.
REQ-008 Port: tick  input  1  frame tick, single-cycle pulse.
REQ-009 Port: btn_start  input  1  debounced start/restart button level.
REQ-010 Port: dinosaur_height  input  6  current jump height (0 = on ground).
REQ-011 Port: obstacle_x  input  10  obstacle left x-coordinate.
REQ-012 Port: obstacle_valid  input  1  obstacle present on screen.
REQ-013 Port: game_status  output  1  1 = running; consumed by jump and ground stages.
REQ-014 Port: speed  output  4  scroll speed, 1..15.
REQ-015 Port: score  output  16  4-digit BCD score, [15:12] thousands.
REQ-016 Port: game_over  output  1  one-cycle pulse on collision.

Function
REQ-017 FSM states: IDLE, RUN, OVER; all outputs registered.
REQ-018 btn_start rising edge: registered previous sample; edge = btn_start & ~prev, usable in the same cycle btn_start first reads 1.
REQ-019 IDLE: start edge -> RUN next edge; score=0, speed=1, divider=0 loaded on that edge.
REQ-020 RUN: game_status=1; evaluation only on cycles with tick=1; start edges ignored.
REQ-021 Collision = obstacle_valid & (obstacle_x+OBST_W > DINO_X) & (obstacle_x < DINO_X+DINO_W) & (dinosaur_height < CLEAR_H); sums computed 11 bits wide, no wrap.
REQ-022 RUN, tick, collision: -> OVER on that edge; game_over=1 for exactly the following cycle; score/speed frozen; no score increment that tick.
REQ-023 RUN, tick, no collision: divider increments; at divider==SCORE_DIV-1, divider->0 and score +1 BCD.
REQ-024 BCD increment: digit 9 -> 0 with carry; score saturates at 9999 (no wrap).
REQ-025 Speed: when a score increment makes low two digits 00 (multiple of 100), speed +1, saturating at 15; no increment at 9999 saturation.
REQ-026 OVER: game_status=0; score/speed held; start edge -> RUN with same clearing as REQ-019.
REQ-027 tick while not RUN: no effect; obstacle/height inputs ignored outside RUN ticks.
REQ-028 game_status, speed, score update on the clock edge where condition sampled; one-cycle latency from tick to output.

Reset
REQ-029 clrn=0 asynchronously forces: state IDLE, game_status=0, speed=1, score=0, game_over=0, divider=0, prev btn sample=0.
REQ-030 clrn deassertion mid-game returns to IDLE; a held btn_start at release counts as a rising edge on the first clocked cycle.

Verification
REQ-031 Reset, btn_start pulse, 12 ticks, obstacle_valid=0 -> game_status=1, score=16'h0002, speed=1.
REQ-032 RUN, obstacle_x=70, height=0, tick -> OVER, game_over high one cycle, game_status=0, score unchanged.
REQ-033 Same as 032 with height=12 -> no collision, stays RUN; obstacle_x=48 (x+W=64, not >64), height=0 -> no collision.
REQ-034 Drive score to 0099, complete one score period -> score=0100, speed=2; at 9999 further ticks -> score stays 9999.
REQ-035 In OVER, btn_start rising edge -> RUN, score=0, speed=1; btn_start held through RUN -> no restart.
REQ-036 clrn low mid-RUN between clock edges -> outputs reset immediately, before next CLK edge.
